// File: rtl/btn_event_if.sv
// Event handshake bundle for btn_event: one queued event presented with valid/code,
// accepted by the consumer through ack.
interface btn_event_if;
   logic       EVT_VALID_O;
   logic [1:0] EVT_CODE_O;
   logic       EVT_ACK_I;

   modport master (output EVT_VALID_O, output EVT_CODE_O, input EVT_ACK_I);
   modport slave  (input EVT_VALID_O, input EVT_CODE_O, output EVT_ACK_I);
endinterface

// File: rtl/btn_event.sv
// Turns a debounced button level into PRESS/RELEASE/LONG/REPEAT events held in a single slot.
// Define BTN_EVENT_REPEAT_EN to enable auto-repeat events while the button stays held.
module btn_event #(
   parameter int unsigned      CNT_W      = 24,
   parameter logic [CNT_W:0]   LONG_MAX   = (CNT_W+1)'(10000000),
   parameter logic [CNT_W:0]   REPEAT_MAX = (CNT_W+1)'(2500000)
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        BTN_I,
   output logic        HELD_O,
   output logic        OVF_O,
   btn_event_if.master evt
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   localparam logic [1:0] EVT_PRESS   = 2'b00;
   localparam logic [1:0] EVT_RELEASE = 2'b01;
   localparam logic [1:0] EVT_LONG    = 2'b10;
`ifdef BTN_EVENT_REPEAT_EN
   localparam logic [1:0] EVT_REPEAT  = 2'b11;
   localparam logic [CNT_W-1:0] RPT_TERM = CNT_W'(REPEAT_MAX - (CNT_W+1)'(1));
`endif
   localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_MAX - (CNT_W+1)'(1));

   if ((LONG_MAX < (CNT_W+1)'(2)) || (REPEAT_MAX < (CNT_W+1)'(2))) begin : g_param_check
      $error("btn_event: LONG_MAX and REPEAT_MAX must both be at least 2");
   end

   logic             btn_q;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q;
   logic [1:0]       code_q;
   logic             held_q;
   logic             ovf_q;

   logic             btn_rise;
   logic             post_d;
   logic [1:0]       post_code_d;

   assign btn_rise = BTN_I & ~btn_q;

   // Next-state and event selection; at most one event per cycle falls out of the transition.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      post_d      = 1'b0;
      post_code_d = EVT_PRESS;
      case (state_q)
         ST_IDLE: begin
            if (btn_rise) begin
               state_d     = ST_PRESSED;
               cnt_d       = '0;
               post_d      = 1'b1;
               post_code_d = EVT_PRESS;
            end
         end
         ST_PRESSED: begin
            if (!BTN_I) begin
               state_d     = ST_IDLE;
               cnt_d       = '0;
               post_d      = 1'b1;
               post_code_d = EVT_RELEASE;
            end else if (cnt_q == LONG_TERM) begin
               state_d     = ST_HOLD;
               cnt_d       = '0;
               post_d      = 1'b1;
               post_code_d = EVT_LONG;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (!BTN_I) begin
               state_d     = ST_IDLE;
               cnt_d       = '0;
               post_d      = 1'b1;
               post_code_d = EVT_RELEASE;
            end else begin
`ifdef BTN_EVENT_REPEAT_EN
               if (cnt_q == RPT_TERM) begin
                  cnt_d       = '0;
                  post_d      = 1'b1;
                  post_code_d = EVT_REPEAT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
`else
               cnt_d = '0;
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         btn_q   <= 1'b0;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         code_q  <= 2'b00;
         held_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         btn_q   <= BTN_I;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         held_q  <= (state_d != ST_IDLE);
         // An ack in the same cycle frees the slot for the incoming event.
         if (post_d) begin
            if (!valid_q || evt.EVT_ACK_I) begin
               valid_q <= 1'b1;
               code_q  <= post_code_d;
            end else begin
               ovf_q <= 1'b1;
            end
         end else if (evt.EVT_ACK_I && valid_q) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign evt.EVT_VALID_O = valid_q;
   assign evt.EVT_CODE_O  = code_q;
   assign HELD_O          = held_q;
   assign OVF_O           = ovf_q;

endmodule

// File: tb/tb_btn_event.sv
// Directed bench for btn_event with LONG_MAX=8, REPEAT_MAX=4, CNT_W=4; expectations follow
// BTN_EVENT_REPEAT_EN the same way the design does.
module tb_btn_event;

   logic CLK;
   logic RST;
   logic BTN_I;
   logic HELD_O;
   logic OVF_O;

   int n_checks;
   int n_fail;

   btn_event_if evt_if ();

   btn_event #(
      .CNT_W      (4),
      .LONG_MAX   (5'd8),
      .REPEAT_MAX (5'd4)
   ) dut (
      .CLK    (CLK),
      .RST    (RST),
      .BTN_I  (BTN_I),
      .HELD_O (HELD_O),
      .OVF_O  (OVF_O),
      .evt    (evt_if.master)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_evt(input string tag, input logic v, input logic [1:0] c);
      check({tag, ".valid"}, 8'(evt_if.EVT_VALID_O), 8'(v));
      if (v) check({tag, ".code"}, 8'(evt_if.EVT_CODE_O), 8'(c));
   endtask

   initial begin
      logic       exp_v;
      logic [1:0] exp_c;
      bit         rpt_en;
      n_checks = 0;
      n_fail   = 0;
`ifdef BTN_EVENT_REPEAT_EN
      rpt_en = 1'b1;
`else
      rpt_en = 1'b0;
`endif
      RST              = 1'b1;
      BTN_I            = 1'b1;
      evt_if.EVT_ACK_I = 1'b1;

      // Reset held with button down
      repeat (3) tick();
      check("rst.valid", 8'(evt_if.EVT_VALID_O), 8'd0);
      check("rst.code",  8'(evt_if.EVT_CODE_O),  8'd0);
      check("rst.held",  8'(HELD_O), 8'd0);
      check("rst.ovf",   8'(OVF_O),  8'd0);
      RST = 1'b0;
      tick();
      check_evt("post_rst_press", 1'b1, 2'b00);
      check("post_rst_press.held", 8'(HELD_O), 8'd1);
      BTN_I = 1'b0;
      tick();
      check_evt("post_rst_release", 1'b1, 2'b01);
      check("post_rst_release.held", 8'(HELD_O), 8'd0);
      tick();
      check_evt("post_rst_idle", 1'b0, 2'b00);

      // Short press: 3 cycles high
      BTN_I = 1'b1;
      for (int i = 0; i <= 3; i++) begin
         BTN_I = (i <= 2);
         tick();
         exp_v = (i == 0) || (i == 3);
         exp_c = (i == 3) ? 2'b01 : 2'b00;
         check_evt($sformatf("short.e%0d", i), exp_v, exp_c);
         check($sformatf("short.e%0d.held", i), 8'(HELD_O), 8'(i <= 2));
      end
      tick();
      check_evt("short.after", 1'b0, 2'b00);

      // Long hold: high for edges 0..20, low at edge 21
      for (int i = 0; i <= 21; i++) begin
         BTN_I = (i <= 20);
         tick();
         exp_v = 1'b0;
         exp_c = 2'b00;
         if (i == 0) begin
            exp_v = 1'b1; exp_c = 2'b00;
         end else if (i == 8) begin
            exp_v = 1'b1; exp_c = 2'b10;
         end else if (i == 21) begin
            exp_v = 1'b1; exp_c = 2'b01;
         end else if (rpt_en && i > 8 && ((i - 8) % 4 == 0)) begin
            exp_v = 1'b1; exp_c = 2'b11;
         end
         check_evt($sformatf("long.e%0d", i), exp_v, exp_c);
         check($sformatf("long.e%0d.held", i), 8'(HELD_O), 8'(i <= 20));
      end
      tick();
      check_evt("long.after", 1'b0, 2'b00);

      // Reset while held, button still down when reset drops
      BTN_I = 1'b1;
      tick();
      check_evt("midrst.press", 1'b1, 2'b00);
      tick();
      tick();
      RST = 1'b1;
      tick();
      check("midrst.valid", 8'(evt_if.EVT_VALID_O), 8'd0);
      check("midrst.held",  8'(HELD_O), 8'd0);
      RST = 1'b0;
      tick();
      check_evt("midrst.repress", 1'b1, 2'b00);
      check("midrst.repress.held", 8'(HELD_O), 8'd1);
      BTN_I = 1'b0;
      tick();
      check_evt("midrst.release", 1'b1, 2'b01);
      tick();

      // Overflow: no ack, RELEASE is dropped
      evt_if.EVT_ACK_I = 1'b0;
      BTN_I = 1'b1;
      tick();
      check_evt("ovf.press", 1'b1, 2'b00);
      tick();
      tick();
      BTN_I = 1'b0;
      tick();
      check_evt("ovf.drop", 1'b1, 2'b00);
      check("ovf.flag", 8'(OVF_O), 8'd1);
      check("ovf.held", 8'(HELD_O), 8'd0);
      evt_if.EVT_ACK_I = 1'b1;
      tick();
      check("ovf.acked.valid", 8'(evt_if.EVT_VALID_O), 8'd0);
      check("ovf.sticky", 8'(OVF_O), 8'd1);
      tick();
      check("ovf.sticky2", 8'(OVF_O), 8'd1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("ovf.cleared", 8'(OVF_O), 8'd0);

      // Ack coincides with RELEASE post while PRESS is pending
      evt_if.EVT_ACK_I = 1'b0;
      BTN_I = 1'b1;
      tick();
      check_evt("ackpost.press", 1'b1, 2'b00);
      BTN_I = 1'b0;
      evt_if.EVT_ACK_I = 1'b1;
      tick();
      check_evt("ackpost.release", 1'b1, 2'b01);
      check("ackpost.ovf", 8'(OVF_O), 8'd0);
      tick();
      check_evt("ackpost.drained", 1'b0, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
